// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Purpose  : Writeback / operand-source stage around the 8-bit ALU. ALU
//            results enter a small write queue through a valid/ready
//            handshake and drain into the register file, updating C/Z flags.
//            Two combinational read ports feed the ALU operands and bypass
//            the youngest pending queue entry. A direct load port has
//            priority over the queue drain.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int DW     = 8,
    parameter int NREGS  = 4,
    parameter int AW     = 2,
    parameter int QDEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          wb_carry,
    input  logic          wb_flag_en,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          c_flag,
    output logic          z_flag,
    output logic          q_empty
);

    // Occupancy counter must represent 0..QDEPTH inclusive.
    localparam int CW = $clog2(QDEPTH + 1);

    // Write queue kept as a shift FIFO: slot 0 is the head (oldest),
    // slot count-1 is the tail (youngest).
    logic [AW-1:0] qa_q [QDEPTH];
    logic [AW-1:0] qa_d [QDEPTH];
    logic [DW-1:0] qd_q [QDEPTH];
    logic [DW-1:0] qd_d [QDEPTH];
    logic          qc_q [QDEPTH];
    logic          qc_d [QDEPTH];
    logic          qf_q [QDEPTH];
    logic          qf_d [QDEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic          c_q;
    logic          c_d;
    logic          z_q;
    logic          z_d;

    logic          push;
    logic          pop;
    logic [CW-1:0] tail;

    // Ready depends only on registered occupancy: no push-through when full.
    assign wb_ready = (count_q < CW'(QDEPTH));
    assign q_empty  = (count_q == '0);
    assign push     = wb_valid & wb_ready;
    assign pop      = (count_q != '0) & ~ld_valid;
    assign tail     = count_q - {{(CW-1){1'b0}}, pop};
    assign c_flag   = c_q;
    assign z_flag   = z_q;

    // Queue next state: shift out the head on pop, then append at the tail.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            qa_d[i] = qa_q[i];
            qd_d[i] = qd_q[i];
            qc_d[i] = qc_q[i];
            qf_d[i] = qf_q[i];
        end
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                qa_d[i] = qa_q[i+1];
                qd_d[i] = qd_q[i+1];
                qc_d[i] = qc_q[i+1];
                qf_d[i] = qf_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (CW'(i) == tail) begin
                    qa_d[i] = wb_addr;
                    qd_d[i] = wb_data;
                    qc_d[i] = wb_carry;
                    qf_d[i] = wb_flag_en;
                end
            end
        end
        count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end

    // Register file and flags next state: load wins over drain; addresses
    // with no matching register simply write nothing.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (ld_valid && (ld_addr == AW'(i))) begin
                regs_d[i] = ld_data;
            end else if (pop && (qa_q[0] == AW'(i))) begin
                regs_d[i] = qd_q[0];
            end
        end
        c_d = c_q;
        z_d = z_q;
        if (pop && qf_q[0]) begin
            c_d = qc_q[0];
            z_d = (qd_q[0] == '0);
        end
    end

    // Read port A: register value, overridden by the youngest pending match.
    always_comb begin
        a_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (ra_addr == AW'(i)) a_out = regs_q[i];
        end
        for (int j = 0; j < QDEPTH; j++) begin
            if ((CW'(j) < count_q) && (qa_q[j] == ra_addr)) a_out = qd_q[j];
        end
    end

    // Read port B: same bypass rule as port A.
    always_comb begin
        b_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rb_addr == AW'(i)) b_out = regs_q[i];
        end
        for (int j = 0; j < QDEPTH; j++) begin
            if ((CW'(j) < count_q) && (qa_q[j] == rb_addr)) b_out = qd_q[j];
        end
    end

    // Queue state; reset discards pending entries without committing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                qa_q[i] <= '0;
                qd_q[i] <= '0;
                qc_q[i] <= 1'b0;
                qf_q[i] <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < QDEPTH; i++) begin
                qa_q[i] <= qa_d[i];
                qd_q[i] <= qd_d[i];
                qc_q[i] <= qc_d[i];
                qf_q[i] <= qf_d[i];
            end
        end
    end

    // Architectural state: registers and C/Z flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb
// Purpose  : Self-checking bench for regfile_wb: directed scenarios followed
//            by randomized traffic, compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;

    localparam int QDEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ra_addr, rb_addr, wb_addr, ld_addr;
    logic [7:0] a_out, b_out, wb_data, ld_data;
    logic       wb_valid, wb_ready, wb_carry, wb_flag_en, ld_valid;
    logic       c_flag, z_flag, q_empty;

    regfile_wb #(.DW(8), .NREGS(4), .AW(2), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .a_out(a_out), .b_out(b_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_carry(wb_carry), .wb_flag_en(wb_flag_en),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .c_flag(c_flag), .z_flag(z_flag), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes as a FIFO of entries, plus registers.
    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        logic       c;
        logic       f;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] mR[4];
    logic       mc, mz;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mread(input logic [1:0] a);
        logic [7:0] v;
        v = mR[a];
        foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 4; i++) mR[i] = 8'h00;
        mc = 1'b0;
        mz = 1'b0;
    endtask

    // One clock cycle: drive inputs, check all outputs against the model,
    // then advance the model across the rising edge.
    task automatic cyc(input logic v, input logic [1:0] wa, input logic [7:0] wd,
                       input logic wc, input logic wf, input logic l,
                       input logic [1:0] la, input logic [7:0] ldd,
                       input logic [1:0] ra, input logic [1:0] rb, output logic acc);
        ent_t e;
        @(negedge clk);
        wb_valid = v; wb_addr = wa; wb_data = wd; wb_carry = wc; wb_flag_en = wf;
        ld_valid = l; ld_addr = la; ld_data = ldd; ra_addr = ra; rb_addr = rb;
        #1;
        chk("wb_ready", wb_ready, mq.size() < QDEPTH);
        chk("q_empty", q_empty, mq.size() == 0);
        chk("a_out", a_out, mread(ra));
        chk("b_out", b_out, mread(rb));
        chk("c_flag", c_flag, mc);
        chk("z_flag", z_flag, mz);
        @(posedge clk);
        acc = v && (mq.size() < QDEPTH);
        if (l) begin
            mR[la] = ldd;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            mR[e.a] = e.d;
            if (e.f) begin
                mc = e.c;
                mz = (e.d == 8'h00);
            end
        end
        if (acc) begin
            e.a = wa; e.d = wd; e.c = wc; e.f = wf;
            mq.push_back(e);
        end
    endtask

    task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
        logic acc;
        cyc(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, ra, rb, acc);
    endtask

    // Reset asserted between edges; its effect must be immediate.
    task automatic mid_reset(input logic [1:0] ra);
        @(negedge clk);
        ra_addr  = ra;
        wb_valid = 1'b0;
        ld_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_q_empty", q_empty, 1);
        chk("rst_wb_ready", wb_ready, 1);
        chk("rst_c", c_flag, 0);
        chk("rst_z", z_flag, 0);
        chk("rst_a_out", a_out, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic       acc;
    logic       pv, pacc;
    logic [1:0] pa;
    logic [7:0] pd;
    logic       pc, pf;

    initial begin
        rst = 1'b1;
        wb_valid = 0; wb_addr = 0; wb_data = 0; wb_carry = 0; wb_flag_en = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0; ra_addr = 0; rb_addr = 0;
        model_reset();
        #1;
        chk("init_q_empty", q_empty, 1);
        chk("init_wb_ready", wb_ready, 1);
        chk("init_c", c_flag, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single push, bypass next cycle, committed after one more edge
        cyc(1, 2'd1, 8'h3C, 1, 1, 0, 0, 8'h00, 2'd1, 2'd1, acc);
        idle(2'd1, 2'd1);
        #1;
        chk("t1_a_out", a_out, 8'h3C);
        chk("t1_c", c_flag, 1);
        chk("t1_z", z_flag, 0);
        chk("t1_q_empty", q_empty, 1);

        // 2: zero result sets Z; a non-flag entry leaves flags alone
        cyc(1, 2'd2, 8'h00, 1, 1, 0, 0, 8'h00, 2'd2, 2'd1, acc);
        cyc(1, 2'd2, 8'h05, 0, 0, 0, 0, 8'h00, 2'd2, 2'd1, acc);
        idle(2'd2, 2'd2);
        #1;
        chk("t2_a_out", a_out, 8'h05);
        chk("t2_c", c_flag, 1);
        chk("t2_z", z_flag, 1);

        // 3: loads block drain; third push stalls until the queue moves
        cyc(1, 2'd0, 8'h10, 0, 1, 1, 2'd3, 8'h77, 2'd0, 2'd3, acc);
        cyc(1, 2'd1, 8'h20, 1, 1, 1, 2'd3, 8'h78, 2'd0, 2'd1, acc);
        cyc(1, 2'd2, 8'h30, 0, 1, 1, 2'd3, 8'h79, 2'd2, 2'd1, acc);
        chk("t3_third_stalled", acc, 0);
        for (int k = 0; k < 8 && !acc; k++)
            cyc(1, 2'd2, 8'h30, 0, 1, 0, 0, 8'h00, 2'd2, 2'd1, acc);
        chk("t3_third_accepted", acc, 1);
        repeat (3) idle(2'd0, 2'd2);

        // 4: two pending writes to one address, youngest is visible
        cyc(1, 2'd0, 8'h11, 0, 0, 1, 2'd1, 8'h01, 2'd0, 2'd0, acc);
        cyc(1, 2'd0, 8'h22, 0, 0, 1, 2'd1, 8'h02, 2'd0, 2'd0, acc);
        #1;
        chk("t4_bypass", a_out, 8'h22);
        repeat (3) idle(2'd0, 2'd1);

        // 5: load under a pending entry is overwritten by the drain
        cyc(1, 2'd3, 8'h55, 0, 0, 1, 2'd2, 8'h66, 2'd3, 2'd3, acc);
        cyc(0, 2'd0, 8'h00, 0, 0, 1, 2'd3, 8'hAA, 2'd3, 2'd3, acc);
        #1;
        chk("t5_bypass", a_out, 8'h55);
        idle(2'd3, 2'd2);
        #1;
        chk("t5_final", a_out, 8'h55);

        // 6: reset with a full queue discards everything
        cyc(1, 2'd1, 8'hE1, 1, 1, 1, 2'd0, 8'h44, 2'd1, 2'd0, acc);
        cyc(1, 2'd2, 8'hE2, 1, 1, 1, 2'd0, 8'h45, 2'd1, 2'd0, acc);
        mid_reset(2'd0);
        for (int k = 0; k < 4; k++) idle(2'(k), 2'(3 - k));

        // Randomized traffic, honouring the stall rule
        pv = 0; pacc = 1; pa = 0; pd = 0; pc = 0; pf = 0;
        for (int it = 0; it < 600; it++) begin
            if (it == 300) mid_reset(2'($urandom_range(0, 3)));
            if (!(pv && !pacc)) begin
                pv = ($urandom_range(0, 9) < 6);
                pa = 2'($urandom_range(0, 3));
                pd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                pc = 1'($urandom);
                pf = 1'($urandom);
            end
            cyc(pv, pa, pd, pc, pf, ($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)), 8'($urandom),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pacc);
        end
        for (int k = 0; k < 4; k++) idle(2'(k), 2'(k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
